// File: rtl/ppu_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_regfile_if
//  Brief    : CPU-side register bus between the bus decoder and the PPU
//             register file ($2000-$2007 window).
//  Revision : 1.0  initial release
// ============================================================================
interface ppu_regfile_if;
    logic       ph2_falling;
    logic       slv_mem_cs;
    logic       slv_mem_rnw;
    logic [2:0] slv_mem_addr;
    logic [7:0] slv_mem_din;
    logic [7:0] slv_mem_dout;

    // CPU bus decoder side
    modport master (
        output ph2_falling, slv_mem_cs, slv_mem_rnw, slv_mem_addr, slv_mem_din,
        input  slv_mem_dout
    );

    // Register file side
    modport slave (
        input  ph2_falling, slv_mem_cs, slv_mem_rnw, slv_mem_addr, slv_mem_din,
        output slv_mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/ppu_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_regfile
//  Brief    : CPU-facing PPU register file: control/mask/status, OAM port,
//             loopy scroll registers (v/t/fine_x/w), buffered PPUDATA with a
//             single-outstanding VRAM request/ack handshake, NMI generation.
//  Revision : 1.0  initial release
// ============================================================================
module ppu_regfile #(
    parameter int VRAM_AW = 14,
    parameter int OAM_AW  = 8,
    parameter int INC_ALT = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    ppu_regfile_if.slave            bus,
    input  wire logic               vblank_set,
    input  wire logic               vblank_clr,
    input  wire logic               spr_hit,
    input  wire logic               spr_ovf,
    input  wire logic               inc_hori,
    input  wire logic               inc_vert,
    input  wire logic               copy_hori,
    input  wire logic               copy_vert,
    output logic                    nmi_n,
    output logic [7:0]              ctrl_out,
    output logic [7:0]              mask_out,
    output logic [14:0]             v_out,
    output logic [14:0]             t_out,
    output logic [2:0]              fine_x,
    output logic [VRAM_AW-1:0]      mem_addr,
    output logic [7:0]              mem_wdata,
    output logic                    mem_wr_req,
    output logic                    mem_rd_req,
    input  wire logic               mem_ack,
    input  wire logic [7:0]         mem_rdata,
    output logic [OAM_AW-1:0]       oam_addr,
    output logic [7:0]              oam_wdata,
    output logic                    oam_we,
    input  wire logic [7:0]         oam_rdata,
    output logic                    dat_overrun
);

    logic [7:0]  ctrl, mask, rd_buf, io_latch, dout;
    logic [14:0] v, t, v_nxt, t_nxt, v_step;
    logic        w, vblank_flag, hit_flag, ovf_flag;
    logic        wr, rd, pending, acc_data, render_en;
    logic [7:0]  din;
    logic [2:0]  addr;

    assign din       = bus.slv_mem_din;
    assign addr      = bus.slv_mem_addr;
    assign wr        = bus.ph2_falling & bus.slv_mem_cs & ~bus.slv_mem_rnw;
    assign rd        = bus.ph2_falling & bus.slv_mem_cs &  bus.slv_mem_rnw;
    assign pending   = mem_wr_req | mem_rd_req;
    assign acc_data  = (wr | rd) && (addr == 3'd7);
    assign render_en = |mask[4:3];
    assign v_step    = ctrl[2] ? 15'(INC_ALT) : 15'd1;

    assign nmi_n     = ~(ctrl[7] & vblank_flag);
    assign ctrl_out  = ctrl;
    assign mask_out  = mask;
    assign v_out     = v;
    assign t_out     = t;
    // OAM writes go straight through so the pulse sees the pre-increment address
    assign oam_we    = wr && (addr == 3'd4) && !rst;
    assign oam_wdata = din;
    assign bus.slv_mem_dout = dout;

    // CPU read mux; write-only registers and idle bus reflect the I/O latch
    always_comb begin
        dout = io_latch;
        if (bus.slv_mem_cs && bus.slv_mem_rnw) begin
            case (addr)
                3'd2:    dout = {vblank_flag, hit_flag, ovf_flag, io_latch[4:0]};
                3'd4:    dout = oam_rdata;
                3'd7:    dout = rd_buf;
                default: dout = io_latch;
            endcase
        end
    end

    // Temporary address t: updated by $2000/$2005/$2006 writes
    always_comb begin
        t_nxt = t;
        if (wr) begin
            case (addr)
                3'd0: t_nxt[11:10] = din[1:0];
                3'd5: begin
                    if (!w) begin
                        t_nxt[4:0]   = din[7:3];
                    end else begin
                        t_nxt[9:5]   = din[7:3];
                        t_nxt[14:12] = din[2:0];
                    end
                end
                3'd6: begin
                    if (!w) begin
                        t_nxt[13:8] = din[5:0];
                        t_nxt[14]   = 1'b0;
                    end else begin
                        t_nxt[7:0]  = din;
                    end
                end
                default: ;
            endcase
        end
    end

    // Current address v: renderer ops lowest, then copies, $2007 step, $2006 load
    always_comb begin
        v_nxt = v;
        if (render_en && inc_hori) begin
            if (v_nxt[4:0] == 5'd31) begin
                v_nxt[4:0] = 5'd0;
                v_nxt[10]  = ~v_nxt[10];
            end else begin
                v_nxt[4:0] = v_nxt[4:0] + 5'd1;
            end
        end
        if (render_en && inc_vert) begin
            if (v_nxt[14:12] != 3'd7) begin
                v_nxt[14:12] = v_nxt[14:12] + 3'd1;
            end else begin
                v_nxt[14:12] = 3'd0;
                if (v_nxt[9:5] == 5'd29) begin
                    v_nxt[9:5] = 5'd0;
                    v_nxt[11]  = ~v_nxt[11];
                end else if (v_nxt[9:5] == 5'd31) begin
                    v_nxt[9:5] = 5'd0;
                end else begin
                    v_nxt[9:5] = v_nxt[9:5] + 5'd1;
                end
            end
        end
        if (render_en && copy_hori) begin
            v_nxt[10]  = t[10];
            v_nxt[4:0] = t[4:0];
        end
        if (render_en && copy_vert) begin
            v_nxt[14:11] = t[14:11];
            v_nxt[9:5]   = t[9:5];
        end
        if (acc_data && !pending) begin
            v_nxt = v + v_step;
        end
        if (wr && (addr == 3'd6) && w) begin
            v_nxt = t_nxt;
        end
    end

    // Register state: ctrl/mask, loopy registers, write toggle, OAM address
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= 8'h00;
            mask     <= 8'h00;
            v        <= 15'd0;
            t        <= 15'd0;
            fine_x   <= 3'd0;
            w        <= 1'b0;
            oam_addr <= '0;
            io_latch <= 8'h00;
        end else begin
            v <= v_nxt;
            t <= t_nxt;
            if (wr) begin
                io_latch <= din;
                case (addr)
                    3'd0: ctrl     <= din;
                    3'd1: mask     <= din;
                    3'd3: oam_addr <= din[OAM_AW-1:0];
                    3'd4: oam_addr <= oam_addr + OAM_AW'(1);
                    3'd5: begin
                        if (!w) fine_x <= din[2:0];
                        w <= ~w;
                    end
                    3'd6: w <= ~w;
                    default: ;
                endcase
            end
            if (rd && (addr == 3'd2)) w <= 1'b0;
        end
    end

    // Status flags: vblank_clr beats any set, a $2002 read beats vblank_set
    always_ff @(posedge clk) begin
        if (rst) begin
            vblank_flag <= 1'b0;
            hit_flag    <= 1'b0;
            ovf_flag    <= 1'b0;
        end else if (vblank_clr) begin
            vblank_flag <= 1'b0;
            hit_flag    <= 1'b0;
            ovf_flag    <= 1'b0;
        end else begin
            if (rd && (addr == 3'd2)) vblank_flag <= 1'b0;
            else if (vblank_set)      vblank_flag <= 1'b1;
            if (spr_hit) hit_flag <= 1'b1;
            if (spr_ovf) ovf_flag <= 1'b1;
        end
    end

    // VRAM handshake: one outstanding request; extra $2007 accesses flag overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            mem_wr_req  <= 1'b0;
            mem_rd_req  <= 1'b0;
            rd_buf      <= 8'h00;
            dat_overrun <= 1'b0;
        end else begin
            if (pending && mem_ack) begin
                if (mem_rd_req) rd_buf <= mem_rdata;
                mem_wr_req <= 1'b0;
                mem_rd_req <= 1'b0;
            end
            if (acc_data) begin
                if (pending) begin
                    dat_overrun <= 1'b1;
                end else begin
                    mem_addr <= v[VRAM_AW-1:0];
                    if (wr) begin
                        mem_wdata  <= din;
                        mem_wr_req <= 1'b1;
                    end else begin
                        mem_rd_req <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppu_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppu_regfile
//  Brief    : Self-checking bench for ppu_regfile: vector table, directed
//             multi-cycle sequences and randomized traffic against a
//             field-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ppu_regfile;
    localparam int VRAM_AW = 14;
    localparam int OAM_AW  = 8;
    localparam int INC_ALT = 32;

    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    ppu_regfile_if bus();

    logic vblank_set, vblank_clr, spr_hit, spr_ovf;
    logic inc_hori, inc_vert, copy_hori, copy_vert;
    logic nmi_n;
    logic [7:0] ctrl_out, mask_out;
    logic [14:0] v_out, t_out;
    logic [2:0] fine_x;
    logic [VRAM_AW-1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic mem_wr_req, mem_rd_req, mem_ack;
    logic [7:0] mem_rdata;
    logic [OAM_AW-1:0] oam_addr;
    logic [7:0] oam_wdata, oam_rdata;
    logic oam_we, dat_overrun;

    ppu_regfile #(.VRAM_AW(VRAM_AW), .OAM_AW(OAM_AW), .INC_ALT(INC_ALT)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .vblank_set(vblank_set), .vblank_clr(vblank_clr),
        .spr_hit(spr_hit), .spr_ovf(spr_ovf),
        .inc_hori(inc_hori), .inc_vert(inc_vert),
        .copy_hori(copy_hori), .copy_vert(copy_vert),
        .nmi_n(nmi_n), .ctrl_out(ctrl_out), .mask_out(mask_out),
        .v_out(v_out), .t_out(t_out), .fine_x(fine_x),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
        .oam_rdata(oam_rdata), .dat_overrun(dat_overrun)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] last_dout;

    // Reference model state (plain integers, PPU field semantics)
    int m_ctrl, m_mask, m_v, m_t, m_fx, m_w, m_oam, m_rdbuf, m_io;
    int m_vb, m_hit, m_ovf, m_ovr, m_wr_req, m_rd_req, m_maddr, m_mwdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_mask = 0; m_v = 0; m_t = 0; m_fx = 0; m_w = 0; m_oam = 0;
        m_rdbuf = 0; m_io = 0; m_vb = 0; m_hit = 0; m_ovf = 0; m_ovr = 0;
        m_wr_req = 0; m_rd_req = 0; m_maddr = 0; m_mwdata = 0;
    endtask

    function automatic int model_dout();
        if (bus.slv_mem_cs && bus.slv_mem_rnw) begin
            case (bus.slv_mem_addr)
                3'd2:    return m_vb * 128 + m_hit * 64 + m_ovf * 32 + (m_io % 32);
                3'd4:    return int'(oam_rdata);
                3'd7:    return m_rdbuf;
                default: return m_io;
            endcase
        end
        return m_io;
    endfunction

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_update();
        bit wr, rd, pend;
        int a, d, nv, cx, cy, nt, fy;
        if (rst) begin
            model_reset();
            return;
        end
        wr = bus.ph2_falling && bus.slv_mem_cs && !bus.slv_mem_rnw;
        rd = bus.ph2_falling && bus.slv_mem_cs &&  bus.slv_mem_rnw;
        a = int'(bus.slv_mem_addr);
        d = int'(bus.slv_mem_din);
        pend = (m_wr_req != 0) || (m_rd_req != 0);

        if (vblank_clr) begin
            m_vb = 0; m_hit = 0; m_ovf = 0;
        end else begin
            if (rd && a == 2) m_vb = 0;
            else if (vblank_set) m_vb = 1;
            if (spr_hit) m_hit = 1;
            if (spr_ovf) m_ovf = 1;
        end

        if (pend && mem_ack) begin
            if (m_rd_req != 0) m_rdbuf = int'(mem_rdata);
            m_wr_req = 0; m_rd_req = 0;
        end

        nv = m_v;
        if ((m_mask & 8'h18) != 0) begin
            cx = m_v % 32; cy = (m_v / 32) % 32; nt = (m_v / 1024) % 4; fy = m_v / 4096;
            if (inc_hori) begin
                cx++;
                if (cx == 32) begin cx = 0; nt = nt ^ 1; end
            end
            if (inc_vert) begin
                fy++;
                if (fy == 8) begin
                    fy = 0;
                    if (cy == 29) begin cy = 0; nt = nt ^ 2; end
                    else if (cy == 31) cy = 0;
                    else cy++;
                end
            end
            if (copy_hori) begin
                cx = m_t % 32;
                nt = (nt & 2) | ((m_t / 1024) & 1);
            end
            if (copy_vert) begin
                cy = (m_t / 32) % 32;
                fy = m_t / 4096;
                nt = (nt & 1) | ((m_t / 1024) & 2);
            end
            nv = fy * 4096 + nt * 1024 + cy * 32 + cx;
        end

        if (wr) m_io = d;
        if ((wr || rd) && a == 7) begin
            if (pend) m_ovr = 1;
            else begin
                m_maddr = m_v % (1 << VRAM_AW);
                if (wr) begin m_mwdata = d; m_wr_req = 1; end
                else m_rd_req = 1;
                nv = (m_v + (((m_ctrl & 4) != 0) ? INC_ALT : 1)) % 32768;
            end
        end
        if (wr) begin
            case (a)
                0: begin m_ctrl = d; m_t = (m_t & ~(3 << 10)) | ((d & 3) << 10); end
                1: m_mask = d;
                3: m_oam = d % (1 << OAM_AW);
                4: m_oam = (m_oam + 1) % (1 << OAM_AW);
                5: begin
                    if (m_w == 0) begin
                        m_t = (m_t & ~31) | (d / 8);
                        m_fx = d % 8;
                    end else begin
                        m_t = (m_t & ~(31 << 5) & ~(7 << 12)) | ((d / 8) << 5) | ((d % 8) << 12);
                    end
                    m_w = 1 - m_w;
                end
                6: begin
                    if (m_w == 0) m_t = (m_t & 8'hFF) | ((d % 64) << 8);
                    else begin
                        m_t = (m_t & ~8'hFF) | d;
                        nv = m_t;
                    end
                    m_w = 1 - m_w;
                end
                default: ;
            endcase
        end
        if (rd && a == 2) m_w = 0;
        m_v = nv;
    endtask

    // One clock: check combinational outputs, clock, then check registered outputs
    task automatic step();
        bit exp_we;
        #1;
        last_dout = bus.slv_mem_dout;
        chk("dout", bus.slv_mem_dout, model_dout());
        exp_we = !rst && bus.ph2_falling && bus.slv_mem_cs && !bus.slv_mem_rnw && bus.slv_mem_addr == 3'd4;
        chk("oam_we", oam_we, exp_we);
        if (exp_we) chk("oam_wdata", oam_wdata, bus.slv_mem_din);
        @(posedge clk);
        model_update();
        #1;
        chk("ctrl_out", ctrl_out, m_ctrl);
        chk("mask_out", mask_out, m_mask);
        chk("v_out", v_out, m_v);
        chk("t_out", t_out, m_t);
        chk("fine_x", fine_x, m_fx);
        chk("nmi_n", nmi_n, !((m_ctrl & 8'h80) != 0 && m_vb != 0));
        chk("mem_wr_req", mem_wr_req, m_wr_req);
        chk("mem_rd_req", mem_rd_req, m_rd_req);
        chk("mem_addr", mem_addr, m_maddr);
        chk("mem_wdata", mem_wdata, m_mwdata);
        chk("oam_addr", oam_addr, m_oam);
        chk("dat_overrun", dat_overrun, m_ovr);
    endtask

    task automatic clear_inputs();
        bus.ph2_falling = 0; bus.slv_mem_cs = 0; bus.slv_mem_rnw = 0;
        bus.slv_mem_addr = 0; bus.slv_mem_din = 0;
        vblank_set = 0; vblank_clr = 0; spr_hit = 0; spr_ovf = 0;
        inc_hori = 0; inc_vert = 0; copy_hori = 0; copy_vert = 0;
        mem_ack = 0;
    endtask

    task automatic bus_op(input bit rnw, input bit [2:0] a, input bit [7:0] d, output logic [7:0] rdv);
        bus.ph2_falling = 1; bus.slv_mem_cs = 1; bus.slv_mem_rnw = rnw;
        bus.slv_mem_addr = a; bus.slv_mem_din = d;
        step();
        rdv = last_dout;
        clear_inputs();
    endtask

    task automatic ack(input bit [7:0] d);
        mem_ack = 1; mem_rdata = d;
        step();
        mem_ack = 0;
    endtask

    typedef struct {
        bit        rnw;
        bit [2:0]  addr;
        bit [7:0]  din;
        bit [14:0] exp_t;
        bit [14:0] exp_v;
        bit [2:0]  exp_fx;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        vecs[0] = '{1'b0, 3'd5, 8'h7D, 15'h000F, 15'h0000, 3'd5};
        vecs[1] = '{1'b0, 3'd5, 8'h5E, 15'h616F, 15'h0000, 3'd5};
        vecs[2] = '{1'b1, 3'd2, 8'h00, 15'h616F, 15'h0000, 3'd5};
        vecs[3] = '{1'b0, 3'd6, 8'h21, 15'h216F, 15'h0000, 3'd5};
        vecs[4] = '{1'b0, 3'd6, 8'h08, 15'h2108, 15'h2108, 3'd5};
        vecs[5] = '{1'b0, 3'd0, 8'h00, 15'h2108, 15'h2108, 3'd5};

        clear_inputs();
        mem_rdata = 0; oam_rdata = 8'h5A;
        model_reset();
        rst = 1;
        step(); step();
        rst = 0;
        step();
        chk("reset_nmi_n", nmi_n, 1'b1);
        chk("reset_v", v_out, 15'h0000);
        chk("reset_req", {mem_wr_req, mem_rd_req}, 2'b00);
        chk("reset_overrun", dat_overrun, 1'b0);

        // scroll/address register vectors
        for (int i = 0; i < 6; i++) begin
            bus_op(vecs[i].rnw, vecs[i].addr, vecs[i].din, r);
            chk($sformatf("vec%0d_t", i), t_out, vecs[i].exp_t);
            chk($sformatf("vec%0d_v", i), v_out, vecs[i].exp_v);
            chk($sformatf("vec%0d_fx", i), fine_x, vecs[i].exp_fx);
        end

        // $2007 write, held until ack
        bus_op(1'b0, 3'd7, 8'hAA, r);
        chk("wr_req", mem_wr_req, 1'b1);
        chk("wr_addr", mem_addr, 14'h2108);
        chk("wr_data", mem_wdata, 8'hAA);
        chk("wr_v", v_out, 15'h2109);
        step(); step();
        chk("wr_held", mem_wr_req, 1'b1);
        ack(8'h00);
        chk("wr_dropped", mem_wr_req, 1'b0);
        bus_op(1'b0, 3'd0, 8'h04, r);
        bus_op(1'b0, 3'd7, 8'h55, r);
        chk("inc32_v", v_out, 15'h2129);
        ack(8'h00);
        bus_op(1'b0, 3'd0, 8'h00, r);

        // buffered read and overrun
        bus_op(1'b1, 3'd7, 8'h00, r);
        chk("rd_first_dout", r, 8'h00);
        chk("rd_req", mem_rd_req, 1'b1);
        chk("rd_addr", mem_addr, 14'h2129);
        ack(8'h3C);
        bus_op(1'b1, 3'd7, 8'h00, r);
        chk("rd_buffered", r, 8'h3C);
        chk("rd2_v", v_out, 15'h212B);
        bus_op(1'b1, 3'd7, 8'h00, r);
        chk("ovr_dout", r, 8'h3C);
        chk("ovr_v", v_out, 15'h212B);
        chk("ovr_flag", dat_overrun, 1'b1);
        ack(8'h77);

        // NMI and status
        vblank_set = 1; step(); vblank_set = 0;
        chk("nmi_masked", nmi_n, 1'b1);
        bus_op(1'b0, 3'd0, 8'h80, r);
        chk("nmi_asserted", nmi_n, 1'b0);
        bus_op(1'b1, 3'd2, 8'h00, r);
        chk("status_vb", r, 8'h80);
        chk("nmi_released", nmi_n, 1'b1);
        vblank_set = 1;
        bus_op(1'b1, 3'd2, 8'h00, r);
        chk("race_dout", r[7], 1'b0);
        bus_op(1'b1, 3'd2, 8'h00, r);
        chk("race_flag", r[7], 1'b0);

        // reset mid-request, late ack ignored
        bus_op(1'b1, 3'd7, 8'h00, r);
        rst = 1; step(); rst = 0;
        chk("rst_drop_req", mem_rd_req, 1'b0);
        ack(8'h99);
        bus_op(1'b1, 3'd7, 8'h00, r);
        chk("late_ack_ignored", r, 8'h00);
        ack(8'h11);

        // renderer v updates
        bus_op(1'b0, 3'd5, 8'h00, r);
        bus_op(1'b0, 3'd5, 8'hEF, r);
        chk("rend_t", t_out, 15'h73A0);
        bus_op(1'b0, 3'd1, 8'h08, r);
        copy_vert = 1; step(); copy_vert = 0;
        chk("copy_vert", v_out, 15'h73A1);
        inc_vert = 1; step(); inc_vert = 0;
        chk("inc_vert_wrap", v_out, 15'h0801);
        for (int i = 0; i < 30; i++) begin
            inc_hori = 1; step(); inc_hori = 0;
        end
        chk("coarse_x_31", v_out, 15'h081F);
        inc_hori = 1; step(); inc_hori = 0;
        chk("inc_hori_wrap", v_out, 15'h0C00);
        bus_op(1'b0, 3'd1, 8'h00, r);
        inc_hori = 1; inc_vert = 1; step(); clear_inputs();
        chk("render_off", v_out, 15'h0C00);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst               = ($urandom_range(0, 499) == 0);
            bus.ph2_falling   = ($urandom_range(0, 2) == 0);
            bus.slv_mem_cs    = ($urandom_range(0, 4) != 0);
            bus.slv_mem_rnw   = $urandom_range(0, 1);
            bus.slv_mem_addr  = $urandom_range(0, 7);
            bus.slv_mem_din   = $urandom_range(0, 255);
            vblank_set        = ($urandom_range(0, 15) == 0);
            vblank_clr        = ($urandom_range(0, 15) == 0);
            spr_hit           = ($urandom_range(0, 9) == 0);
            spr_ovf           = ($urandom_range(0, 9) == 0);
            inc_hori          = ($urandom_range(0, 3) == 0);
            inc_vert          = ($urandom_range(0, 5) == 0);
            copy_hori         = ($urandom_range(0, 7) == 0);
            copy_vert         = ($urandom_range(0, 7) == 0);
            mem_ack           = (m_wr_req != 0 || m_rd_req != 0) ? ($urandom_range(0, 2) == 0)
                                                                 : ($urandom_range(0, 29) == 0);
            mem_rdata         = $urandom_range(0, 255);
            oam_rdata         = $urandom_range(0, 255);
            step();
        end
        rst = 0;
        clear_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
